cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Miss handler and memory arbiter between the I-cache, the D-cache and the shared unified main memory.
- On a cache miss it fetches the 8-word (16-byte) block from the pipelined 4-cycle memory and streams the words into the requesting cache's data array, then pulses a done signal so the cache writes its tag/valid.
- It also forwards D-cache write-through stores to memory.
- The pipeline stalls while either cache reports a miss; this block is what clears that stall.

Parameters:
- MEM_LATENCY, 4, cycles from mem_en to the matching mem_data_valid.
- WORDS_PER_BLOCK, 8, words per cache block; power of 2; block offset bits = log2(WORDS_PER_BLOCK)+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_miss  in  1  I-cache miss pending (level, held until i_fill_done)
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss pending (level, held until d_fill_done)
- d_miss_addr  in  16  D-cache miss byte address
- d_store  in  1  write-through store request (level, held until d_store_ack)
- d_store_addr  in  16  store byte address
- d_store_data  in  16  store data
- d_store_ack  out  1  1-cycle pulse: store issued to memory
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  word-aligned byte address (bit 0 = 0)
- mem_wdata  out  16  write data
- mem_data_out  in  16  read data
- mem_data_valid  in  1  read data valid (MEM_LATENCY after issue)
- fill_data  out  16  word to write into the cache
- fill_word  out  3  word index within the block
- i_fill_we  out  1  write fill_data into I-cache at fill_word
- d_fill_we  out  1  write fill_data into D-cache at fill_word
- i_fill_done  out  1  1-cycle pulse: I-block complete, write tag/valid
- d_fill_done  out  1  1-cycle pulse: D-block complete, write tag/valid
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, all counters 0, every output 0. Reset mid-fill abandons the fill; no done pulse is issued. Any mem_data_valid arriving after reset while in IDLE is ignored.
- States: IDLE, STORE, FILL, DONE. A register `owner` (I or D) is latched when a fill is accepted.
- IDLE arbitration, fixed priority: d_store > d_miss > i_miss.
  - d_store → STORE.
  - d_miss → FILL with owner=D, base={d_miss_addr[15:4],4'b0}.
  - i_miss → FILL with owner=I, base={i_miss_addr[15:4],4'b0}.
  - The decision is made on the cycle the request is seen in IDLE.
- STORE (one cycle): mem_en=1, mem_wr=1, mem_addr={d_store_addr[15:1],1'b0}, mem_wdata=d_store_data, d_store_ack=1. Then → IDLE.
- FILL issue side:
  - Issue counter ic (0..8).
  - While ic<8: mem_en=1, mem_wr=0, mem_addr=base+2*ic, ic++.
  - Issue is one word per cycle, with no gaps.
- FILL receive side:
  - Receive counter rc (0..8).
  - Each cycle mem_data_valid=1: fill_data=mem_data_out, fill_word=rc[2:0], and the owner's fill_we=1 for that same cycle (combinational). Then rc++.
- Transition: when rc reaches 8 → DONE. DONE pulses the owner's fill_done for one cycle, then → IDLE.
- Latency (no stalls): request seen in IDLE at cycle 0.
  - Issues occur in cycles 1..8.
  - Data arrives in cycles 5..12.
  - fill_done pulses in cycle 13.
  - A new request can be accepted in cycle 14.
- Miss deassertion mid-fill: ignored; the fill always completes. Requests arriving during FILL wait; they are not queued.
- mem_data_valid outside FILL: ignored.
- Width rules:
  - base+2*ic wraps modulo 2^16.
  - ic and rc are 4 bits.
  - fill_word is the low 3 bits of the logical word index.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - Issue order starts at the missed word w0 = miss_addr[3:1] and wraps: mem_addr = base + 2*((w0+ic) mod 8).
  - fill_word = (w0+rc) mod 8.
  - Register early_word_valid (output, 1 bit) pulses with the first fill_we of each fill, so the stalled stage can be released early.
- Undefined: order starts at word 0; early_word_valid is absent from the port list.

Test Plan:
- Reset mid-fill: assert rst_n=0 at fill cycle 6 → all outputs 0 next cycle, no fill_done. A later i_miss fill completes normally.
- I-miss, addr 0x0036: mem_addr sequence 0x0030,0x0032,…,0x003E in cycles 1-8. i_fill_we with fill_word 0..7 in cycles 5-12. i_fill_done in cycle 13. d_fill_we never asserted.
- Simultaneous d_miss 0x1002, i_miss 0x0100, d_store 0x2004/0xBEEF:
  - Store issued first (mem_wr=1, addr 0x2004, data 0xBEEF, d_store_ack).
  - Then D fill of 0x1000-0x100E with d_fill_done.
  - Then I fill of 0x0100-0x010E.
- d_miss dropped at fill cycle 3 → fill still completes, 8 d_fill_we pulses, d_fill_done.
- Wrap: d_miss_addr 0xFFF4 → addresses 0xFFF0..0xFFFE with no overflow into 0x0000. With CRITICAL_WORD_FIRST_EN: order 0xFFF4,0xFFF6,…,0xFFFE,0xFFF0,0xFFF2 and fill_word 2,3,…,7,0,1.
- Stray mem_data_valid=1 in IDLE, data 0x1234 → no fill_we, no state change, busy stays 0.

Source files
------------

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: memory-side bus between the fill controller and the
// shared unified main memory.
//   mem_en         access this cycle
//   mem_wr         1 = write, 0 = read
//   mem_addr       word-aligned byte address
//   mem_wdata      write data
//   mem_data_out   read data returned by memory
//   mem_data_valid read data valid, a fixed latency after the read issue
// master: the fill controller; slave: the memory.
interface cache_fill_ctrl_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_data_out, mem_data_valid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_data_out, mem_data_valid
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss handler and memory arbiter for the I-cache and D-cache.
// Fetches a whole block from pipelined memory on a miss, streams the words
// into the owning cache, pulses that cache's fill_done, and forwards D-cache
// write-through stores. Fixed priority: d_store > d_miss > i_miss.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   i_miss, i_miss_addr              I-cache miss request (level)
//   d_miss, d_miss_addr              D-cache miss request (level)
//   d_store, d_store_addr/_data      write-through store request (level)
//   d_store_ack                      store issued pulse
//   mem                              memory bus (cache_fill_ctrl_if.master)
//   fill_data, fill_word             word and its index for the cache array
//   i_fill_we, d_fill_we             per-cache array write enable
//   i_fill_done, d_fill_done         block complete pulse (write tag/valid)
//   early_word_valid                 first word of a fill delivered
//                                    (only with CRITICAL_WORD_FIRST_EN)
//   busy                             controller not idle
// Build option: define CRITICAL_WORD_FIRST_EN to fetch the missed word first
// and wrap around the block.
module cache_fill_ctrl #(
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_miss,
  input  logic [15:0]                           i_miss_addr,
  input  logic                                  d_miss,
  input  logic [15:0]                           d_miss_addr,
  input  logic                                  d_store,
  input  logic [15:0]                           d_store_addr,
  input  logic [15:0]                           d_store_data,
  output logic                                  d_store_ack,
  cache_fill_ctrl_if.master                     mem,
  output logic [15:0]                           fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0]    fill_word,
  output logic                                  i_fill_we,
  output logic                                  d_fill_we,
  output logic                                  i_fill_done,
  output logic                                  d_fill_done,
`ifdef CRITICAL_WORD_FIRST_EN
  output logic                                  early_word_valid,
`endif
  output logic                                  busy
);

  localparam int unsigned AddrW    = 16;
  localparam int unsigned WordBits = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned OffBits  = WordBits + 1;
  localparam int unsigned CntW     = WordBits + 1;
  localparam int unsigned BlkW     = AddrW - OffBits;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STORE = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Elaboration-time sanity on the configuration.
  if (MEM_LATENCY < 1) begin : gBadLatency
    $error("cache_fill_ctrl: MEM_LATENCY must be at least 1");
  end
  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : gBadWords
    $error("cache_fill_ctrl: WORDS_PER_BLOCK must be a power of 2");
  end

  logic [1:0]          state;
  logic [1:0]          nextState;
  logic                ownerD;      // 1 = D-cache owns the current fill
  logic [BlkW-1:0]     blockAddr;   // block-aligned upper address bits
  logic [CntW-1:0]     ic;          // words issued
  logic [CntW-1:0]     rc;          // words received
  logic [WordBits-1:0] w0;          // first word of the fill order
  logic                acceptD_c;
  logic                acceptI_c;
  logic                issue_c;
  logic                recv_c;
  logic [WordBits-1:0] issueWord;
  logic [WordBits-1:0] recvWord;

  // Low address bits only matter in the critical-word-first build.
  logic unusedBits;
  assign unusedBits = ^{i_miss_addr[OffBits-1:0], d_miss_addr[OffBits-1:0], d_store_addr[0]};

  // Logical word index rotated by the starting word; wraps within the block.
  assign issueWord = WordBits'(w0 + ic[WordBits-1:0]);
  assign recvWord  = WordBits'(w0 + rc[WordBits-1:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and output decode.
  always_comb begin
    nextState      = state;
    acceptD_c      = 1'b0;
    acceptI_c      = 1'b0;
    issue_c        = 1'b0;
    recv_c         = 1'b0;
    mem.mem_en     = 1'b0;
    mem.mem_wr     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    d_store_ack    = 1'b0;
    fill_data      = '0;
    fill_word      = '0;
    i_fill_we      = 1'b0;
    d_fill_we      = 1'b0;
    i_fill_done    = 1'b0;
    d_fill_done    = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (d_store) begin
          nextState = STORE;
        end else if (d_miss) begin
          nextState = FILL;
          acceptD_c = 1'b1;
        end else if (i_miss) begin
          nextState = FILL;
          acceptI_c = 1'b1;
        end
      end
      STORE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = {d_store_addr[AddrW-1:1], 1'b0};
        mem.mem_wdata = d_store_data;
        d_store_ack   = 1'b1;
        nextState     = IDLE;
      end
      FILL: begin
        // Issue side: one read per cycle until every word is requested.
        if (!ic[CntW-1]) begin
          issue_c      = 1'b1;
          mem.mem_en   = 1'b1;
          mem.mem_addr = {blockAddr, issueWord, 1'b0};
        end
        // Receive side: returned words go straight to the owning cache.
        if (mem.mem_data_valid && !rc[CntW-1]) begin
          recv_c    = 1'b1;
          fill_data = mem.mem_data_out;
          fill_word = recvWord;
          d_fill_we = ownerD;
          i_fill_we = !ownerD;
          if (rc == CntW'(WORDS_PER_BLOCK - 1)) nextState = DONE;
        end
      end
      DONE: begin
        d_fill_done = ownerD;
        i_fill_done = !ownerD;
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Fill bookkeeping: owner, block address and the two word counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ownerD    <= 1'b0;
      blockAddr <= '0;
      ic        <= '0;
      rc        <= '0;
    end else begin
      if (acceptD_c) begin
        ownerD    <= 1'b1;
        blockAddr <= d_miss_addr[AddrW-1:OffBits];
      end else if (acceptI_c) begin
        ownerD    <= 1'b0;
        blockAddr <= i_miss_addr[AddrW-1:OffBits];
      end
      if (state == IDLE) begin
        ic <= '0;
        rc <= '0;
      end else begin
        if (issue_c) ic <= ic + CntW'(1);
        if (recv_c)  rc <= rc + CntW'(1);
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  // Starting word of the fill is the word that missed.
  always_ff @(posedge clk) begin
    if (!rst_n)         w0 <= '0;
    else if (acceptD_c) w0 <= d_miss_addr[OffBits-1:1];
    else if (acceptI_c) w0 <= i_miss_addr[OffBits-1:1];
  end

  // The critical word is the first one delivered in each fill.
  assign early_word_valid = recv_c && (rc == '0);
`else
  assign w0 = '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed self-checking bench for cache_fill_ctrl with a
// 4-cycle pipelined memory model returning data = addr ^ 16'h5A5A.
module tb_cache_fill_ctrl;
  logic        clk;
  logic        rst_n;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_store;
  logic [15:0] d_store_addr;
  logic [15:0] d_store_data;
  logic        d_store_ack;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        busy;
`ifdef CRITICAL_WORD_FIRST_EN
  logic        early_word_valid;
`endif

  int total = 0;
  int bad   = 0;

  cache_fill_ctrl_if memBus();

  cache_fill_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_miss       (i_miss),
    .i_miss_addr  (i_miss_addr),
    .d_miss       (d_miss),
    .d_miss_addr  (d_miss_addr),
    .d_store      (d_store),
    .d_store_addr (d_store_addr),
    .d_store_data (d_store_data),
    .d_store_ack  (d_store_ack),
    .mem          (memBus),
    .fill_data    (fill_data),
    .fill_word    (fill_word),
    .i_fill_we    (i_fill_we),
    .d_fill_we    (d_fill_we),
    .i_fill_done  (i_fill_done),
    .d_fill_done  (d_fill_done),
`ifdef CRITICAL_WORD_FIRST_EN
    .early_word_valid (early_word_valid),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined memory: a read issued in cycle t returns in cycle t+4.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  logic        stray = 1'b0;
  logic [15:0] strayData = '0;

  always @(posedge clk) begin
    pv    <= {pv[2:0], (memBus.mem_en === 1'b1) && (memBus.mem_wr === 1'b0)};
    pa[0] <= memBus.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end

  assign memBus.mem_data_valid = pv[3] | stray;
  assign memBus.mem_data_out   = stray ? strayData : (pa[3] ^ 16'h5A5A);

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Walks cycles 1..13 of a fill whose request was presented in cycle 0
  // (caller is at the cycle-0 negedge); drops the miss at cycle dropAt.
  task automatic fillCheck(input bit isD, input logic [15:0] missAddr, input int dropAt);
    logic [11:0] blk;
    logic [2:0]  w0;
    logic [2:0]  w;
    logic [15:0] ea;
    bit          inData;
    blk = missAddr[15:4];
`ifdef CRITICAL_WORD_FIRST_EN
    w0 = missAddr[3:1];
`else
    w0 = 3'd0;
`endif
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checkEq("busy", 32'(busy), 32'd1);
      if (k <= 8) begin
        w  = w0 + 3'(k - 1);
        ea = {blk, w, 1'b0};
        checkEq("memEn", 32'(memBus.mem_en), 32'd1);
        checkEq("memWr", 32'(memBus.mem_wr), 32'd0);
        checkEq("memAddr", 32'(memBus.mem_addr), 32'(ea));
      end else begin
        checkEq("memEnIdle", 32'(memBus.mem_en), 32'd0);
      end
      inData = (k >= 5) && (k <= 12);
      if (inData) begin
        w  = w0 + 3'(k - 5);
        ea = {blk, w, 1'b0};
        checkEq("fillWord", 32'(fill_word), 32'(w));
        checkEq("fillData", 32'(fill_data), 32'(ea ^ 16'h5A5A));
`ifdef CRITICAL_WORD_FIRST_EN
        checkEq("earlyWord", 32'(early_word_valid), 32'(k == 5));
`endif
      end
      checkEq("iFillWe", 32'(i_fill_we), 32'(inData && !isD));
      checkEq("dFillWe", 32'(d_fill_we), 32'(inData && isD));
      checkEq("iFillDone", 32'(i_fill_done), 32'(k == 13 && !isD));
      checkEq("dFillDone", 32'(d_fill_done), 32'(k == 13 && isD));
      if (k == dropAt) begin
        if (isD) d_miss = 1'b0;
        else     i_miss = 1'b0;
      end
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkEq({tag, ".busy"},  32'(busy), 32'd0);
    checkEq({tag, ".memEn"}, 32'(memBus.mem_en), 32'd0);
    checkEq({tag, ".iWe"},   32'(i_fill_we), 32'd0);
    checkEq({tag, ".dWe"},   32'(d_fill_we), 32'd0);
    checkEq({tag, ".iDone"}, 32'(i_fill_done), 32'd0);
    checkEq({tag, ".dDone"}, 32'(d_fill_done), 32'd0);
    checkEq({tag, ".ack"},   32'(d_store_ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_miss = 1'b0; i_miss_addr = '0;
    d_miss = 1'b0; d_miss_addr = '0;
    d_store = 1'b0; d_store_addr = '0; d_store_data = '0;

    // Reset state.
    repeat (5) @(negedge clk);
    checkQuiet("reset");
    checkEq("reset.memWr", 32'(memBus.mem_wr), 32'd0);
    checkEq("reset.memAddr", 32'(memBus.mem_addr), 32'd0);
    rst_n = 1'b1;

    // I-miss at 0x0036.
    @(negedge clk);
    i_miss = 1'b1; i_miss_addr = 16'h0036;
    fillCheck(1'b0, 16'h0036, 13);
    @(negedge clk);
    checkQuiet("afterI");

    // Simultaneous store, D-miss and I-miss: store, then D fill, then I fill.
    d_store = 1'b1; d_store_addr = 16'h2004; d_store_data = 16'hBEEF;
    d_miss = 1'b1;  d_miss_addr = 16'h1002;
    i_miss = 1'b1;  i_miss_addr = 16'h0100;
    @(negedge clk);
    checkEq("store.memEn", 32'(memBus.mem_en), 32'd1);
    checkEq("store.memWr", 32'(memBus.mem_wr), 32'd1);
    checkEq("store.memAddr", 32'(memBus.mem_addr), 32'h2004);
    checkEq("store.wdata", 32'(memBus.mem_wdata), 32'hBEEF);
    checkEq("store.ack", 32'(d_store_ack), 32'd1);
    checkEq("store.busy", 32'(busy), 32'd1);
    d_store = 1'b0;
    @(negedge clk);
    checkQuiet("postStore");
    fillCheck(1'b1, 16'h1002, 13);
    @(negedge clk);
    checkQuiet("betweenDI");
    fillCheck(1'b0, 16'h0100, 13);
    @(negedge clk);
    checkQuiet("afterDI");

    // D-miss dropped at fill cycle 3 still completes.
    d_miss = 1'b1; d_miss_addr = 16'h0480;
    fillCheck(1'b1, 16'h0480, 3);
    @(negedge clk);
    checkQuiet("afterDrop");

    // Block at the top of the address space.
    d_miss = 1'b1; d_miss_addr = 16'hFFF4;
    fillCheck(1'b1, 16'hFFF4, 13);
    @(negedge clk);
    checkQuiet("afterWrap");

    // Stray read data while idle.
    stray = 1'b1; strayData = 16'h1234;
    #1;
    checkEq("stray.iWe", 32'(i_fill_we), 32'd0);
    checkEq("stray.dWe", 32'(d_fill_we), 32'd0);
    @(negedge clk);
    stray = 1'b0;
    checkQuiet("stray");
    @(negedge clk);
    checkQuiet("strayAfter");

    // Reset in the middle of an I fill.
    i_miss = 1'b1; i_miss_addr = 16'h0200;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    i_miss = 1'b0;
    @(negedge clk);
    checkQuiet("midReset");
    checkEq("midReset.memWr", 32'(memBus.mem_wr), 32'd0);
    checkEq("midReset.memAddr", 32'(memBus.mem_addr), 32'd0);
    checkEq("midReset.fillData", 32'(fill_data), 32'd0);
    checkEq("midReset.fillWord", 32'(fill_word), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkQuiet("postReset");
    end

    // A later I fill completes normally.
    i_miss = 1'b1; i_miss_addr = 16'h0208;
    fillCheck(1'b0, 16'h0208, 13);
    @(negedge clk);
    checkQuiet("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
